// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bundle: instruction memory request/response, redirect and decode handshake.
interface instr_fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;

    // Fetch stage side
    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, dec_ready
    );

    // Memory / branch unit / decode side
    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, dec_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads and
// buffers returned words with their PC in an in-order FIFO for decode.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_OUT  = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clock,
    input  logic                 reset,
    instr_fetch_queue_if.master  bus
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned TAG_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_count;
    logic [OUT_W-1:0] r_out;
    logic [OUT_W-1:0] r_discard;
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [TAG_W-1:0] r_tag_wr;
    logic [TAG_W-1:0] r_tag_rd;

    logic [31:0]      r_tag_pc   [MAX_OUT];
    logic [31:0]      r_fifo_pc  [DEPTH];
    logic [31:0]      r_fifo_data[DEPTH];

    logic [SUM_W-1:0] w_used;
    logic             w_credit;
    logic             w_req_fire;
    logic             w_rsp;
    logic             w_drop;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic [TAG_W-1:0] w_tag_wr_nxt;
    logic [TAG_W-1:0] w_tag_rd_nxt;
    logic             w_unused;

    // Credit: every accepted request owns a FIFO slot until its response returns
    assign w_used     = SUM_W'(r_count) + SUM_W'(r_out);
    assign w_credit   = (r_out < OUT_W'(MAX_OUT)) && (w_used < SUM_W'(DEPTH));
    assign w_req_fire = bus.imem_req_valid && bus.imem_req_ready;

    // Responses with nothing in flight are ignored
    assign w_rsp  = bus.imem_rsp_valid && (r_out != '0);
    assign w_drop = w_rsp && (r_discard != '0);
    assign w_push = w_rsp && (r_discard == '0) && !bus.redirect_valid;
    assign w_pop  = bus.dec_valid && bus.dec_ready;

    assign w_empty = (r_count == '0);

    assign w_tag_wr_nxt = (r_tag_wr == TAG_W'(MAX_OUT - 1)) ? '0 : r_tag_wr + TAG_W'(1);
    assign w_tag_rd_nxt = (r_tag_rd == TAG_W'(MAX_OUT - 1)) ? '0 : r_tag_rd + TAG_W'(1);

    // Outputs: request gated off while in reset or redirecting; head shown as 0 when empty
    assign bus.imem_req_valid = reset && !bus.redirect_valid && w_credit;
    assign bus.imem_req_addr  = r_pc;
    assign bus.dec_valid      = !w_empty && !bus.redirect_valid;
    assign bus.dec_instr      = w_empty ? 32'h0 : r_fifo_data[r_head];
    assign bus.dec_pc         = w_empty ? 32'h0 : r_fifo_pc[r_head];

    // Low address bits of the redirect target are forced to zero
    assign w_unused = ^bus.redirect_pc[1:0];

    // Control state: PC, FIFO occupancy/pointers, in-flight and discard counters
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_count   <= '0;
            r_out     <= '0;
            r_discard <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
        end else begin
            if (bus.redirect_valid) begin
                r_pc      <= {bus.redirect_pc[31:2], 2'b00};
                r_count   <= '0;
                r_head    <= '0;
                r_tail    <= '0;
                r_discard <= r_out - OUT_W'(w_rsp);
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_drop) begin
                    r_discard <= r_discard - OUT_W'(1);
                end
                if (w_push) begin
                    r_tail <= r_tail + PTR_W'(1);
                end
                if (w_pop) begin
                    r_head <= r_head + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end

            if (w_req_fire && !w_rsp) begin
                r_out <= r_out + OUT_W'(1);
            end else if (!w_req_fire && w_rsp) begin
                r_out <= r_out - OUT_W'(1);
            end

            if (w_req_fire) begin
                r_tag_wr <= w_tag_wr_nxt;
            end
            if (w_rsp) begin
                r_tag_rd <= w_tag_rd_nxt;
            end
        end
    end

    // Storage: in-flight PC tags and FIFO payload (contents qualified by pointers/count)
    always_ff @(posedge clock) begin
        if (w_req_fire) begin
            r_tag_pc[r_tag_wr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_tail]   <= r_tag_pc[r_tag_rd];
            r_fifo_data[r_tail] <= bus.imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: randomized memory latency, backpressure and redirects.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          due;
        int          epoch;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    instr_fetch_queue_if bus();

    instr_fetch_queue #(
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT),
        .RESET_PC(RESET_PC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    req_t        pend[$];
    item_t       exp_q[$];
    logic [31:0] popped[$];
    logic [31:0] m_pc = RESET_PC;
    int          epoch = 0;
    int          cyc = 0;
    int          fires = 0;
    int          pops = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          n_tests = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: samples the cycle at negedge, applies it at the following posedge
    initial begin
        logic        s_rst, s_fire, s_rsp, s_redir;
        logic [31:0] s_rpc;
        req_t        r;
        forever begin
            @(negedge clock);
            s_rst   = reset;
            s_fire  = bus.imem_req_valid && bus.imem_req_ready;
            s_rsp   = bus.imem_rsp_valid;
            s_redir = bus.redirect_valid;
            s_rpc   = bus.redirect_pc;
            @(posedge clock);
            cyc++;
            if (!reset || !s_rst) begin
                pend.delete();
                exp_q.delete();
                m_pc  = RESET_PC;
                fires = 0;
                pops  = 0;
                epoch++;
            end else begin
                if (s_rsp && pend.size() > 0) begin
                    r = pend.pop_front();
                    if (!s_redir && r.epoch == epoch)
                        exp_q.push_back('{pc: r.addr, instr: mem_word(r.addr)});
                end
                if (s_fire) begin
                    pend.push_back('{addr: m_pc,
                                     due: cyc + $urandom_range(lat_hi, lat_lo) - 1,
                                     epoch: epoch});
                    m_pc = m_pc + 32'd4;
                    fires++;
                end
                if (s_redir) begin
                    epoch++;
                    exp_q.delete();
                    m_pc = s_rpc & ~32'd3;
                end
            end
        end
    end

    // Memory responder: returns words in request order once their latency has elapsed
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        forever begin
            @(posedge clock);
            #1;
            if (reset && pend.size() > 0 && pend[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = mem_word(pend[0].addr);
            end else begin
                bus.imem_rsp_valid = 1'b0;
                bus.imem_rsp_data  = $urandom();
            end
        end
    end

    // Monitor: compares DUT outputs against the model and pops on decode handshakes
    initial begin
        logic exp_dv, exp_rv;
        forever begin
            @(negedge clock);
            if (!reset) begin
                check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
                check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
                check("rst_dec_pc", bus.dec_pc, 32'h0);
                check("rst_dec_instr", bus.dec_instr, 32'h0);
            end else begin
                exp_dv = (exp_q.size() != 0) && !bus.redirect_valid;
                exp_rv = !bus.redirect_valid && (pend.size() < MAX_OUT) &&
                         (exp_q.size() + pend.size() < DEPTH);
                check("dec_valid", 32'(bus.dec_valid), 32'(exp_dv));
                check("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
                check("req_addr", bus.imem_req_addr, m_pc);
                if (exp_q.size() != 0) begin
                    check("dec_pc", bus.dec_pc, exp_q[0].pc);
                    check("dec_instr", bus.dec_instr, exp_q[0].instr);
                end else begin
                    check("empty_dec_pc", bus.dec_pc, 32'h0);
                    check("empty_dec_instr", bus.dec_instr, 32'h0);
                end
                if (bus.dec_valid && bus.dec_ready && exp_q.size() > 0) begin
                    popped.push_back(exp_q[0].pc);
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Asynchronous reset pulse asserted mid-cycle; outputs must clear immediately
    task automatic do_reset();
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("async_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("async_dec_pc", bus.dec_pc, 32'h0);
        check("async_dec_instr", bus.dec_instr, 32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = pc;
        popped.delete();
        step(1);
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = $urandom();
    endtask

    task automatic wait_pend(input int n, input string name);
        int k;
        k = 0;
        while (pend.size() != n && k < 30) begin
            step(1);
            k++;
        end
        check(name, 32'(pend.size()), 32'(n));
    endtask

    initial begin
        int          p0;
        int          f0;
        int          k;
        logic [31:0] a0;

        bus.imem_req_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.dec_ready      = 1'b0;
        step(2);
        reset = 1'b1;

        // Streaming at latency 1: in-order delivery, one instruction per cycle
        bus.imem_req_ready = 1'b1;
        bus.dec_ready      = 1'b1;
        popped.delete();
        step(10);
        check("t1_first_pc", popped.size() > 0 ? popped[0] : 32'hDEAD_BEEF, 32'h0);
        check("t1_fourth_pc", popped.size() > 3 ? popped[3] : 32'hDEAD_BEEF, 32'hC);
        p0 = pops;
        step(10);
        check("t1_throughput", 32'(pops - p0), 32'd10);

        // Decode stalled: exactly DEPTH requests fill the queue, then fetch resumes
        do_reset();
        bus.dec_ready = 1'b0;
        popped.delete();
        step(12);
        check("t2_fires", 32'(fires), 32'd4);
        check("t2_req_stalled", 32'(bus.imem_req_valid), 32'd0);
        bus.dec_ready = 1'b1;
        step(10);
        check("t2_pop4_pc", popped.size() > 3 ? popped[3] : 32'hDEAD_BEEF, 32'hC);
        check("t2_resume_pc", popped.size() > 4 ? popped[4] : 32'hDEAD_BEEF, 32'h10);

        // Redirect with two requests in flight: both responses dropped
        lat_lo = 3;
        lat_hi = 3;
        wait_pend(2, "t3_two_outstanding");
        pulse_redirect(32'h0000_0103);
        k = 0;
        while (popped.size() == 0 && k < 30) begin
            step(1);
            k++;
        end
        check("t3_first_after_redirect", popped.size() > 0 ? popped[0] : 32'hDEAD_BEEF, 32'h100);

        // Redirect near the top of the address space: PC wraps to zero
        lat_lo = 1;
        lat_hi = 1;
        step(3);
        pulse_redirect(32'hFFFF_FFF8);
        step(12);
        check("t4_pc0", popped.size() > 0 ? popped[0] : 32'hDEAD_BEEF, 32'hFFFF_FFF8);
        check("t4_pc1", popped.size() > 1 ? popped[1] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
        check("t4_pc2", popped.size() > 2 ? popped[2] : 32'hDEAD_BEEF, 32'h0);

        // Memory not ready: address held, PC not advanced
        bus.imem_req_ready = 1'b0;
        a0 = bus.imem_req_addr;
        f0 = fires;
        for (int i = 0; i < 5; i++) begin
            step(1);
            check("t5_addr_hold", bus.imem_req_addr, a0);
        end
        check("t5_no_fire", 32'(fires), 32'(f0));
        bus.imem_req_ready = 1'b1;
        step(4);

        // Randomized traffic: latency, backpressure and occasional redirects
        lat_lo = 1;
        lat_hi = 4;
        for (int i = 0; i < 1500; i++) begin
            bus.imem_req_ready = ($urandom_range(3, 0) != 0);
            bus.dec_ready      = ($urandom_range(9, 0) < 7);
            if ($urandom_range(31, 0) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = $urandom();
            end else begin
                bus.redirect_valid = 1'b0;
            end
            step(1);
        end
        bus.redirect_valid = 1'b0;

        // Reset mid-stream with three queued instructions: no stale output afterwards
        lat_lo = 1;
        lat_hi = 1;
        bus.imem_req_ready = 1'b1;
        bus.dec_ready      = 1'b0;
        k = 0;
        while (exp_q.size() != 3 && k < 30) begin
            step(1);
            k++;
        end
        check("t6_count3", 32'(exp_q.size()), 32'd3);
        do_reset();
        popped.delete();
        bus.dec_ready = 1'b1;
        step(10);
        check("t6_restart_pc", popped.size() > 0 ? popped[0] : 32'hDEAD_BEEF, RESET_PC);
        check("t6_second_pc", popped.size() > 1 ? popped[1] : 32'hDEAD_BEEF, RESET_PC + 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
